// File: rtl/gt_cell_pkg.sv
// Shared constants for the gt_cell registered magnitude comparator.
// The operand width itself stays a module parameter; these are its defaults and limits.
package gt_cell_pkg;

  localparam int GT_DEFAULT_WIDTH = 4;
  localparam int GT_MAX_WIDTH     = 64;

endpackage : gt_cell_pkg

// File: rtl/gt_cell_if.sv
// Operand/result bundle for gt_cell.
// The master drives both operands, and the comparator (slave) returns the registered result.
interface gt_cell_if #(
  parameter int WIDTH = gt_cell_pkg::GT_DEFAULT_WIDTH
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out;

  modport master (
    output a,
    output b,
    input  out
  );

  modport slave (
    input  a,
    input  b,
    output out
  );

endinterface : gt_cell_if

// File: rtl/gt_cell_slice.sv
// One bit of the MSB-to-LSB greater-than ripple chain.
// The first differing bit, scanning down from the MSB, decides the result.
module gt_bit_slice (
  input  logic a_i,
  input  logic b_i,
  input  logic gt_in,
  input  logic eq_in,
  output logic gt_out,
  output logic eq_out
);

  assign gt_out = gt_in | (eq_in & a_i & ~b_i);
  assign eq_out = eq_in & ~(a_i ^ b_i);

endmodule : gt_bit_slice

// File: rtl/gt_cell.sv
// Registered unsigned comparator: out = (a > b), with one cycle of latency.
// The output comes from a ripple chain of gt_bit_slice instances feeding a single flop.
module gt_cell
  import gt_cell_pkg::*;
#(
  parameter int WIDTH = GT_DEFAULT_WIDTH
) (
  input  logic       clk,
  input  logic       rst,
  gt_cell_if.slave   bus
);

  logic [WIDTH:0] w_gt;
  logic [WIDTH:1] w_eq;
  logic           w_lsbEqUnused;
  logic           r_out;

  // The chain enters at the MSB with "nothing decided yet, still equal so far".
  assign w_gt[WIDTH] = 1'b0;
  assign w_eq[WIDTH] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    if (i > 0) begin : g_mid
      gt_bit_slice u_slice (
        .a_i   (bus.a[i]),
        .b_i   (bus.b[i]),
        .gt_in (w_gt[i+1]),
        .eq_in (w_eq[i+1]),
        .gt_out(w_gt[i]),
        .eq_out(w_eq[i])
      );
    end else begin : g_lsb
      // The LSB equality output has no consumer; the chain ends at its gt output.
      gt_bit_slice u_slice (
        .a_i   (bus.a[i]),
        .b_i   (bus.b[i]),
        .gt_in (w_gt[i+1]),
        .eq_in (w_eq[i+1]),
        .gt_out(w_gt[i]),
        .eq_out(w_lsbEqUnused)
      );
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out <= 1'b0;
    end else begin
      r_out <= w_gt[0];
    end
  end

  assign bus.out = r_out;

endmodule : gt_cell

// File: tb/tb_gt_cell.sv
// Self-checking bench for gt_cell, using WIDTH=4, WIDTH=1 and WIDTH=16 instances.
// It combines a vector table, hand-written reset sequences and scoreboarded sweeps.
module tb_gt_cell;

  logic clk;
  logic rst;

  gt_cell_if #(.WIDTH(4))  bus4  ();
  gt_cell_if #(.WIDTH(1))  bus1  ();
  gt_cell_if #(.WIDTH(16)) bus16 ();

  gt_cell #(.WIDTH(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4));
  gt_cell #(.WIDTH(1))  u_dut1  (.clk(clk), .rst(rst), .bus(bus1));
  gt_cell #(.WIDTH(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic  exp;
    string tag;
  } sb_t;

  sb_t q4[$];
  sb_t q1[$];
  sb_t q16[$];

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       exp;
    string      tag;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string tag, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: out=%b expected=%b at t=%0t", tag, act, exp, $time);
    end
  endtask

  // Waits for the capture edge and then compares every pending scoreboard entry.
  task automatic stepAndCheck();
    sb_t e;
    @(posedge clk);
    #1;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      checkOutput(e.tag, bus4.out, e.exp);
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      checkOutput(e.tag, bus1.out, e.exp);
    end
    if (q16.size() > 0) begin
      e = q16.pop_front();
      checkOutput(e.tag, bus16.out, e.exp);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] a, input logic [3:0] b,
                               input logic exp, input string tag);
    @(negedge clk);
    bus4.a = a;
    bus4.b = b;
    q4.push_back('{exp: exp, tag: tag});
    stepAndCheck();
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    logic        r1a;
    logic        r1b;
    logic [3:0]  sa;
    logic [3:0]  sb;

    // Reset is applied from time zero, with a > b already on the operands.
    rst      = 1'b1;
    bus4.a   = 4'd3;
    bus4.b   = 4'd1;
    bus1.a   = 1'b0;
    bus1.b   = 1'b0;
    bus16.a  = 16'd0;
    bus16.b  = 16'd0;
    #2;
    checkOutput("reset_async", bus4.out, 1'b0);
    checkOutput("reset_async_w1", bus1.out, 1'b0);
    checkOutput("reset_async_w16", bus16.out, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("reset_held", bus4.out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_released_no_edge", bus4.out, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("first_edge_after_reset", bus4.out, 1'b1);

    vecs.push_back('{a: 4'd0,  b: 4'd0,  exp: 1'b0, tag: "seq_0_0"});
    vecs.push_back('{a: 4'd2,  b: 4'd0,  exp: 1'b1, tag: "seq_2_0"});
    vecs.push_back('{a: 4'd3,  b: 4'd1,  exp: 1'b1, tag: "seq_3_1"});
    vecs.push_back('{a: 4'd4,  b: 4'd6,  exp: 1'b0, tag: "seq_4_6"});
    vecs.push_back('{a: 4'd3,  b: 4'd2,  exp: 1'b1, tag: "seq_3_2"});
    vecs.push_back('{a: 4'd7,  b: 4'd7,  exp: 1'b0, tag: "equal_7_7"});
    vecs.push_back('{a: 4'd15, b: 4'd0,  exp: 1'b1, tag: "ones_vs_zeros"});
    vecs.push_back('{a: 4'd0,  b: 4'd15, exp: 1'b0, tag: "zeros_vs_ones"});
    vecs.push_back('{a: 4'd8,  b: 4'd7,  exp: 1'b1, tag: "msb_decides_8_7"});
    vecs.push_back('{a: 4'd5,  b: 4'd4,  exp: 1'b1, tag: "lsb_only_5_4"});
    vecs.push_back('{a: 4'd4,  b: 4'd5,  exp: 1'b0, tag: "lsb_only_4_5"});
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].tag);
    end

    // Reset mid-stream: a pending (9,2) compare must be discarded while out drops at once.
    applyStimulus(4'd3, 4'd2, 1'b1, "pre_midreset_3_2");
    @(negedge clk);
    bus4.a = 4'd9;
    bus4.b = 4'd2;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("midstream_reset_async", bus4.out, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("midstream_reset_held", bus4.out, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(4'd1, 4'd9, 1'b0, "post_reset_1_9");
    applyStimulus(4'd9, 4'd1, 1'b1, "post_reset_9_1");

    // Back-to-back sweep: every WIDTH=4 pair, with random WIDTH=1 and WIDTH=16 pairs alongside.
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      sa  = i[7:4];
      sb  = i[3:0];
      r1a = 1'($urandom_range(0, 1));
      r1b = 1'($urandom_range(0, 1));
      ra  = 16'($urandom);
      if (i % 8 == 0) begin
        rb = ra;
      end else if (i == 1) begin
        ra = 16'hFFFF;
        rb = 16'h0000;
      end else if (i == 2) begin
        ra = 16'h0000;
        rb = 16'hFFFF;
      end else if (i % 8 == 3) begin
        rb = ra ^ 16'h0001;
      end else begin
        rb = 16'($urandom);
      end
      bus4.a  = sa;
      bus4.b  = sb;
      bus1.a  = r1a;
      bus1.b  = r1b;
      bus16.a = ra;
      bus16.b = rb;
      q4.push_back('{exp: (sa > sb), tag: "sweep_w4"});
      q1.push_back('{exp: (r1a > r1b), tag: "sweep_w1"});
      q16.push_back('{exp: (ra > rb), tag: "sweep_w16"});
      stepAndCheck();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_gt_cell
